// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_arb_pkg : shared types and defaults for the data RAM port arbiter     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package dmem_arb_pkg;

   localparam int c_def_addr_w = 14;
   localparam int c_def_data_w = 32;

   typedef logic [1:0] state_t;
   localparam state_t c_st_idle      = 2'd0;
   localparam state_t c_st_issue_cpu = 2'd1;
   localparam state_t c_st_issue_upg = 2'd2;

   typedef enum logic {
      GNT_CPU = 1'b0,
      GNT_UPG = 1'b1
   } grant_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_pick2 : combinational two-way round-robin pick with CPU force override  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rr_pick2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  grant_t     last_grant,
   input  logic       force_cpu,
   output grant_t     grant
);

   // req[0] is the CPU, req[1] the UART side; with no request the result is unused
   always_comb begin
      grant = GNT_UPG;
      if (req[0] && (force_cpu || !req[1] || (last_grant == GNT_UPG)))
         grant = GNT_CPU;
   end

endmodule
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_port_arbiter : shares dmemory32 between CPU and UART programmer ports |
// | Optional macro DMEM_ARB_UPG_LOCK_EN locks the CPU out during upg_active.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W    = c_def_addr_w,
   parameter int DATA_W    = c_def_data_w,
   parameter int BURST_MAX = 4
)(
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_adr,
   input  logic [DATA_W-1:0] cpu_wdat,
   output logic [DATA_W-1:0] cpu_rdat,
   output logic              cpu_ack,
   output logic              cpu_stall,
   input  logic              upg_req,
   input  logic              upg_we,
   input  logic [ADDR_W-1:0] upg_adr,
   input  logic [DATA_W-1:0] upg_wdat,
   output logic [DATA_W-1:0] upg_rdat,
   output logic              upg_ack,
   input  logic              upg_active,
   output logic              ram_wen,
   output logic [ADDR_W-1:0] ram_adr,
   output logic [DATA_W-1:0] ram_wdat,
   input  logic [DATA_W-1:0] ram_rdat
);

   localparam int                   c_burst_w   = $clog2(BURST_MAX + 1);
   localparam logic [c_burst_w-1:0] c_burst_max = BURST_MAX[c_burst_w-1:0];

   state_t              r_state;
   grant_t              r_last_grant;
   logic [c_burst_w-1:0] r_burst_cnt;
   logic [ADDR_W-1:0]   r_adr_hold;
   logic [DATA_W-1:0]   r_wdat_hold;
   logic [DATA_W-1:0]   r_cpu_rdat;
   logic [DATA_W-1:0]   r_upg_rdat;

   logic   w_lock;
   logic   w_cpu_elig;
   logic   w_force_cpu;
   logic   w_accept;
   logic   w_cpu_win;
   grant_t w_grant;

`ifdef DMEM_ARB_UPG_LOCK_EN
   assign w_lock = upg_active;
`else
   logic w_unused_upg_active;
   assign w_lock              = 1'b0;
   assign w_unused_upg_active = upg_active;
`endif

   assign w_cpu_elig  = cpu_req & ~w_lock;
   assign w_force_cpu = w_cpu_elig & ~w_lock & (r_burst_cnt == c_burst_max);

   rr_pick2 u_pick (
      .req        ({upg_req, w_cpu_elig}),
      .last_grant (r_last_grant),
      .force_cpu  (w_force_cpu),
      .grant      (w_grant)
   );

   // Gating with reset keeps a mid-access reset from producing a late ack
   assign w_accept  = (r_state == c_st_idle) & (w_cpu_elig | upg_req) & ~reset;
   assign w_cpu_win = (w_grant == GNT_CPU);

   assign ram_wen   = w_accept & (w_cpu_win ? cpu_we : upg_we);
   assign ram_adr   = w_accept ? (w_cpu_win ? cpu_adr  : upg_adr)  : r_adr_hold;
   assign ram_wdat  = w_accept ? (w_cpu_win ? cpu_wdat : upg_wdat) : r_wdat_hold;

   assign cpu_ack   = (r_state == c_st_issue_cpu) & ~reset;
   assign upg_ack   = (r_state == c_st_issue_upg) & ~reset;
   assign cpu_rdat  = cpu_ack ? ram_rdat : r_cpu_rdat;
   assign upg_rdat  = upg_ack ? ram_rdat : r_upg_rdat;
   assign cpu_stall = cpu_req & ~(w_accept & w_cpu_win);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= c_st_idle;
         r_last_grant <= GNT_UPG;
         r_burst_cnt  <= '0;
         r_adr_hold   <= '0;
         r_wdat_hold  <= '0;
         r_cpu_rdat   <= '0;
         r_upg_rdat   <= '0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (w_accept) begin
                  r_state      <= w_cpu_win ? c_st_issue_cpu : c_st_issue_upg;
                  r_last_grant <= w_grant;
                  r_adr_hold   <= ram_adr;
                  r_wdat_hold  <= ram_wdat;
               end
               // Burst count saturates so a long UART run cannot wrap back to zero
               if (w_accept && !w_cpu_win) begin
                  if (r_burst_cnt != c_burst_max)
                     r_burst_cnt <= r_burst_cnt + 1'b1;
               end else if (w_accept || !upg_req) begin
                  r_burst_cnt <= '0;
               end
            end
            c_st_issue_cpu: begin
               r_cpu_rdat <= ram_rdat;
               r_state    <= c_st_idle;
            end
            c_st_issue_upg: begin
               r_upg_rdat <= ram_rdat;
               r_state    <= c_st_idle;
            end
            default: r_state <= c_st_idle;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dmem_port_arbiter : self-checking bench for dmem_port_arbiter           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_dmem_port_arbiter;

   localparam int BURST_MAX = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0, upg_req = 1'b0, upg_we = 1'b0, upg_active = 1'b0;
   logic [13:0] cpu_adr = '0, upg_adr = '0;
   logic [31:0] cpu_wdat = '0, upg_wdat = '0;
   logic [31:0] cpu_rdat, upg_rdat, ram_wdat, ram_rdat;
   logic        cpu_ack, cpu_stall, upg_ack, ram_wen;
   logic [13:0] ram_adr;

   logic [31:0] mem [0:(1<<14)-1] = '{default: 32'h0};

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clock = ~clock;

   // Behavioural dmemory32: registered read of the old contents, synchronous write
   always @(posedge clock) begin
      ram_rdat <= mem[ram_adr];
      if (ram_wen) mem[ram_adr] <= ram_wdat;
   end

   dmem_port_arbiter #(.ADDR_W(14), .DATA_W(32), .BURST_MAX(BURST_MAX)) dut (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdat(cpu_wdat),
      .cpu_rdat(cpu_rdat), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
      .upg_req(upg_req), .upg_we(upg_we), .upg_adr(upg_adr), .upg_wdat(upg_wdat),
      .upg_rdat(upg_rdat), .upg_ack(upg_ack), .upg_active(upg_active),
      .ram_wen(ram_wen), .ram_adr(ram_adr), .ram_wdat(ram_wdat), .ram_rdat(ram_rdat)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   typedef struct packed {
      logic creq, cwe; logic [13:0] cadr; logic [31:0] cwd;
      logic ureq, uwe; logic [13:0] uadr; logic [31:0] uwd;
      logic e_cack, e_uack, e_wen, e_stall; logic [13:0] e_adr;
      logic chk_cr; logic [31:0] e_cr; logic chk_ur; logic [31:0] e_ur;
   } vec_t;

   // Transaction-level reference: who is being served, who won last, UART run length
   int          m_busy, m_last, m_burst;
   logic [13:0] m_adr_hold;
   logic [31:0] m_wdat_hold;
   logic [31:0] m_rd_exp [2];
   logic        m_is_read [2];
   logic [31:0] shadow [16];

   task automatic model_reset();
      m_busy = -1; m_last = 1; m_burst = 0; m_adr_hold = '0; m_wdat_hold = '0;
      m_is_read[0] = 1'b0; m_is_read[1] = 1'b0;
   endtask

   task automatic model_step();
      int win; logic lk, we; logic [13:0] adr; logic [31:0] wd;
      lk = 1'b0;
`ifdef DMEM_ARB_UPG_LOCK_EN
      lk = upg_active;
`endif
      check("rnd cpu_ack", cpu_ack, m_busy == 0);
      check("rnd upg_ack", upg_ack, m_busy == 1);
      if (m_busy == 0 && m_is_read[0]) check("rnd cpu_rdat", cpu_rdat, m_rd_exp[0]);
      if (m_busy == 1 && m_is_read[1]) check("rnd upg_rdat", upg_rdat, m_rd_exp[1]);
      win = -1;
      if (m_busy < 0) begin
         if ((cpu_req && !lk) && upg_req)
            win = (!lk && m_burst >= BURST_MAX) ? 0 : ((m_last == 1) ? 0 : 1);
         else if (cpu_req && !lk) win = 0;
         else if (upg_req)        win = 1;
      end
      we  = (win == 0) ? cpu_we   : (win == 1) ? upg_we   : 1'b0;
      adr = (win == 0) ? cpu_adr  : (win == 1) ? upg_adr  : m_adr_hold;
      wd  = (win == 0) ? cpu_wdat : (win == 1) ? upg_wdat : m_wdat_hold;
      check("rnd ram_wen", ram_wen, we);
      check("rnd ram_adr", ram_adr, adr);
      check("rnd cpu_stall", cpu_stall, cpu_req && (win != 0));
      if (we) check("rnd ram_wdat", ram_wdat, wd);
      if (win >= 0) begin
         m_busy = win; m_last = win; m_adr_hold = adr; m_wdat_hold = wd;
         m_is_read[win] = !we;
         if (we) shadow[adr[3:0]] = wd;
         else    m_rd_exp[win] = shadow[adr[3:0]];
         if (win == 1) m_burst = (m_burst < BURST_MAX) ? m_burst + 1 : m_burst;
         else          m_burst = 0;
      end else begin
         if (m_busy < 0 && !upg_req) m_burst = 0;
         m_busy = -1;
      end
   endtask

   task automatic idle_inputs();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wdat = '0;
      upg_req = 1'b0; upg_we = 1'b0; upg_adr = '0; upg_wdat = '0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      idle_inputs(); upg_active = 1'b0; reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      model_reset();
   endtask

   vec_t vecs [12];
   int   c_run, max_run, n_cack, got;
   logic c_pend, c_we2, u_pend, u_we2, ack_c, ack_u;
   logic [13:0] c_adr2, u_adr2;
   logic [31:0] c_wd2, u_wd2;

   initial begin
      vecs[0]  = '{1'b1,1'b1,14'h010,32'hDEADBEEF, 1'b0,1'b0,14'h0,32'h0, 1'b0,1'b0,1'b1,1'b0,14'h010, 1'b0,32'h0,1'b0,32'h0};
      vecs[1]  = '{1'b1,1'b1,14'h010,32'hDEADBEEF, 1'b0,1'b0,14'h0,32'h0, 1'b1,1'b0,1'b0,1'b1,14'h010, 1'b0,32'h0,1'b0,32'h0};
      vecs[2]  = '{1'b1,1'b0,14'h010,32'h0,        1'b0,1'b0,14'h0,32'h0, 1'b0,1'b0,1'b0,1'b0,14'h010, 1'b0,32'h0,1'b0,32'h0};
      vecs[3]  = '{1'b1,1'b0,14'h010,32'h0,        1'b0,1'b0,14'h0,32'h0, 1'b1,1'b0,1'b0,1'b1,14'h010, 1'b1,32'hDEADBEEF,1'b0,32'h0};
      vecs[4]  = '{1'b0,1'b0,14'h0,32'h0,          1'b0,1'b0,14'h0,32'h0, 1'b0,1'b0,1'b0,1'b0,14'h010, 1'b0,32'h0,1'b0,32'h0};
      vecs[5]  = '{1'b1,1'b0,14'h020,32'h0, 1'b1,1'b1,14'h030,32'h12345678, 1'b0,1'b0,1'b1,1'b1,14'h030, 1'b0,32'h0,1'b0,32'h0};
      vecs[6]  = '{1'b1,1'b0,14'h020,32'h0, 1'b1,1'b1,14'h030,32'h12345678, 1'b0,1'b1,1'b0,1'b1,14'h030, 1'b0,32'h0,1'b0,32'h0};
      vecs[7]  = '{1'b1,1'b0,14'h020,32'h0,        1'b0,1'b0,14'h0,32'h0, 1'b0,1'b0,1'b0,1'b0,14'h020, 1'b0,32'h0,1'b0,32'h0};
      vecs[8]  = '{1'b0,1'b0,14'h0,32'h0,        1'b1,1'b0,14'h030,32'h0, 1'b1,1'b0,1'b0,1'b0,14'h020, 1'b1,32'h0,1'b0,32'h0};
      vecs[9]  = '{1'b0,1'b0,14'h0,32'h0,        1'b1,1'b0,14'h030,32'h0, 1'b0,1'b0,1'b0,1'b0,14'h030, 1'b0,32'h0,1'b0,32'h0};
      vecs[10] = '{1'b0,1'b0,14'h0,32'h0,          1'b0,1'b0,14'h0,32'h0, 1'b0,1'b1,1'b0,1'b0,14'h030, 1'b0,32'h0,1'b1,32'h12345678};
      vecs[11] = '{1'b0,1'b0,14'h0,32'h0,          1'b0,1'b0,14'h0,32'h0, 1'b0,1'b0,1'b0,1'b0,14'h030, 1'b0,32'h0,1'b0,32'h0};
      for (int i = 0; i < 16; i++) shadow[i] = 32'h0;

      // Reset state
      repeat (2) @(negedge clock);
      #1;
      check("rst cpu_ack", cpu_ack, 0);   check("rst upg_ack", upg_ack, 0);
      check("rst ram_wen", ram_wen, 0);   check("rst ram_adr", ram_adr, 0);
      check("rst ram_wdat", ram_wdat, 0); check("rst cpu_rdat", cpu_rdat, 0);
      check("rst upg_rdat", upg_rdat, 0);
      reset = 1'b0;

      // Directed vector table: write/read-back, arbitration, req drop during issue
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         cpu_req = vecs[i].creq; cpu_we = vecs[i].cwe; cpu_adr = vecs[i].cadr; cpu_wdat = vecs[i].cwd;
         upg_req = vecs[i].ureq; upg_we = vecs[i].uwe; upg_adr = vecs[i].uadr; upg_wdat = vecs[i].uwd;
         #1;
         check($sformatf("vec%0d cpu_ack", i), cpu_ack, vecs[i].e_cack);
         check($sformatf("vec%0d upg_ack", i), upg_ack, vecs[i].e_uack);
         check($sformatf("vec%0d ram_wen", i), ram_wen, vecs[i].e_wen);
         check($sformatf("vec%0d ram_adr", i), ram_adr, vecs[i].e_adr);
         check($sformatf("vec%0d cpu_stall", i), cpu_stall, vecs[i].e_stall);
         if (vecs[i].chk_cr) check($sformatf("vec%0d cpu_rdat", i), cpu_rdat, vecs[i].e_cr);
         if (vecs[i].chk_ur) check($sformatf("vec%0d upg_rdat", i), upg_rdat, vecs[i].e_ur);
      end

      // Simultaneous requests after reset alternate CPU, UPG, CPU, UPG
      do_reset();
      @(negedge clock);
      cpu_req = 1'b1; cpu_adr = 14'h001; upg_req = 1'b1; upg_adr = 14'h002;
      for (int c = 0; c < 8; c++) begin
         if (c > 0) @(negedge clock);
         #1;
         check($sformatf("alt c%0d cpu_ack", c), cpu_ack, (c == 1) || (c == 5));
         check($sformatf("alt c%0d upg_ack", c), upg_ack, (c == 3) || (c == 7));
      end

      // Long UART burst, then CPU joins: UART run between CPU acks stays bounded
      do_reset();
      @(negedge clock);
      upg_req = 1'b1; upg_adr = 14'h003;
      repeat (12) @(negedge clock);
      cpu_req = 1'b1; cpu_adr = 14'h004;
      c_run = 0; max_run = 0; n_cack = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (cpu_ack) begin n_cack++; c_run = 0; end
         if (upg_ack) begin c_run++; if (c_run > max_run) max_run = c_run; end
         @(negedge clock);
      end
      check("burst run bounded", max_run <= BURST_MAX, 1);
      check("burst cpu served", n_cack >= 4, 1);

      // Reset asserted during ISSUE_UPG
      do_reset();
      @(negedge clock);
      upg_req = 1'b1; upg_we = 1'b1; upg_adr = 14'h005; upg_wdat = 32'hAAAA5555;
      #1 check("rstmid accept wen", ram_wen, 1);
      @(negedge clock);
      reset = 1'b1; upg_req = 1'b0;
      #1 check("rstmid no upg_ack", upg_ack, 0);
      @(negedge clock);
      #1;
      check("rstmid upg_ack", upg_ack, 0);   check("rstmid cpu_ack", cpu_ack, 0);
      check("rstmid ram_wen", ram_wen, 0);   check("rstmid ram_adr", ram_adr, 0);
      check("rstmid ram_wdat", ram_wdat, 0); check("rstmid upg_rdat", upg_rdat, 0);
      check("rstmid cpu_rdat", cpu_rdat, 0);
      reset = 1'b0;
      @(negedge clock);
      idle_inputs(); cpu_req = 1'b1; cpu_adr = 14'h007; upg_req = 1'b1; upg_adr = 14'h008;
      #1;
      check("rstmid cpu first adr", ram_adr, 14'h007);
      check("rstmid cpu no stall", cpu_stall, 0);
      @(negedge clock);
      #1 check("rstmid cpu_ack", cpu_ack, 1);

`ifdef DMEM_ARB_UPG_LOCK_EN
      // UART lock holds the CPU off until upg_active falls
      do_reset();
      @(negedge clock);
      upg_active = 1'b1; cpu_req = 1'b1; cpu_adr = 14'h009;
      n_cack = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         check($sformatf("lock c%0d cpu_stall", c), cpu_stall, 1);
         if (cpu_ack) n_cack++;
         @(negedge clock);
      end
      check("lock zero cpu_ack", n_cack, 0);
      upg_active = 1'b0;
      got = 0;
      for (int c = 0; c < 3 && got == 0; c++) begin
         #1;
         if (cpu_ack) got = 1;
         if (got == 0) @(negedge clock);
      end
      check("unlock cpu_ack in 2", got, 1);
`endif

      // Randomized traffic against the reference model
      do_reset();
      c_pend = 1'b0; u_pend = 1'b0;
      c_we2 = 1'b0; u_we2 = 1'b0; c_adr2 = 14'h100; u_adr2 = 14'h100; c_wd2 = '0; u_wd2 = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clock);
         ack_c = (m_busy == 0);
         ack_u = (m_busy == 1);
         if (ack_c || !c_pend) begin
            c_pend = ($urandom % 4) != 0; c_we2 = $urandom % 2;
            c_adr2 = 14'h100 | 14'($urandom % 16); c_wd2 = $urandom;
         end
         if (ack_u || !u_pend) begin
            u_pend = ($urandom % 4) != 0; u_we2 = $urandom % 2;
            u_adr2 = 14'h100 | 14'($urandom % 16); u_wd2 = $urandom;
         end
`ifdef DMEM_ARB_UPG_LOCK_EN
         if ($urandom % 10 == 0) upg_active = ~upg_active;
`endif
         cpu_req = c_pend; cpu_we = c_we2; cpu_adr = c_adr2; cpu_wdat = c_wd2;
         upg_req = u_pend; upg_we = u_we2; upg_adr = u_adr2; upg_wdat = u_wd2;
         #1;
         model_step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
